// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus interface unit: state encoding,
// default bus widths and the word-alignment test.
package cpu_bus_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } bus_state_t;

    // True when the two low address bits describe a word-aligned access.
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/cpu_bus_master_if.sv
// CPU-side request/response signals and Wishbone-classic master signals
// of the bus interface unit, bundled with master (unit) and slave
// (environment) views.
interface cpu_bus_master_if
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    // Handshake: the CPU holds cpu_req/cpu_we/cpu_addr/cpu_wdata, and the
    // request is taken on a rising edge where cpu_req=1 and cpu_ready=1.
    // Exactly one cpu_done pulse (with cpu_err) answers each taken request.
    // On the bus side, a cycle runs while W_CYC=W_STB=1 and ends on the
    // first rising edge that sees W_ACK=1; W_ACK outside a cycle is ignored.
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_done;
    logic              cpu_err;
    logic [DATA_W-1:0] cpu_rdata;

    logic [ADDR_W-1:0] W_ADDR;
    logic [DATA_W-1:0] W_DAT_O;
    logic [DATA_W-1:0] W_DAT_I;
    logic              W_ACK;
    logic              W_CYC;
    logic              W_STB;
    logic              W_WE;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, W_DAT_I, W_ACK,
        output cpu_ready, cpu_done, cpu_err, cpu_rdata,
               W_ADDR, W_DAT_O, W_CYC, W_STB, W_WE
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, W_DAT_I, W_ACK,
        input  cpu_ready, cpu_done, cpu_err, cpu_rdata,
               W_ADDR, W_DAT_O, W_CYC, W_STB, W_WE
    );

endinterface

// File: rtl/cpu_bus_timeout.sv
// Bus-wait watchdog counter: cleared when a bus cycle starts, advanced on
// every waiting cycle, and flags the terminal count so the cycle can be
// abandoned. Instantiated only when CPU_BUS_TIMEOUT_EN is defined.
module cpu_bus_timeout
    import cpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count waiting cycles; a fresh bus cycle always restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == TERMINAL);

endmodule

// File: rtl/cpu_bus_master.sv
// Bus interface unit between the CPU control FSM and a Wishbone-classic
// bus. One single-word load/store/fetch is in flight at a time; the result
// is reported with a one-cycle cpu_done pulse, flagged by cpu_err for a
// misaligned address or an abandoned bus cycle.
// Optional feature: define CPU_BUS_TIMEOUT_EN to abandon a bus cycle that
// has waited TIMEOUT_CYCLES cycles without W_ACK. Without it the unit
// waits for W_ACK indefinitely.
module cpu_bus_master
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             W_RST,
    cpu_bus_master_if.master bus,
    output bus_state_t       state_dbg
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("cpu_bus_master: TIMEOUT_CYCLES must be at least 2");
    end

    bus_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;
    logic              cyc_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              start;
    logic              timeout_hit;

    assign accept = (state == IDLE) && bus.cpu_req;
    assign start  = accept && is_aligned(bus.cpu_addr[1:0]);

`ifdef CPU_BUS_TIMEOUT_EN
    cpu_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (W_RST),
        .clr    (start),
        .en     ((state == BUS) && !bus.W_ACK),
        .expire (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Request/bus-cycle FSM; every CPU- and bus-facing output is a register here.
    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (start) begin
                            addr_q  <= bus.cpu_addr;
                            wdata_q <= bus.cpu_wdata;
                            we_q    <= bus.cpu_we;
                            cyc_q   <= 1'b1;
                            state   <= BUS;
                        end else begin
                            // Misaligned: refuse without touching the bus.
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    if (bus.W_ACK) begin
                        // An ack in the terminal-count cycle still completes normally.
                        if (!we_q) begin
                            rdata_q <= bus.W_DAT_I;
                        end
                        cyc_q  <= 1'b0;
                        we_q   <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else if (timeout_hit) begin
                        cyc_q  <= 1'b0;
                        we_q   <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ready = (state == IDLE);
    assign bus.cpu_done  = done_q;
    assign bus.cpu_err   = err_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.W_ADDR    = addr_q;
    assign bus.W_DAT_O   = wdata_q;
    assign bus.W_WE      = we_q;
    assign bus.W_CYC     = cyc_q;
    assign bus.W_STB     = cyc_q;
    assign state_dbg     = state;

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Bus interface unit directly downstream of the CPU control FSM.
- Converts the CPU's single-word load, store and fetch requests into Wishbone-style classic master cycles (W_CYC/W_STB/W_WE/W_ADDR/W_DAT_O, W_DAT_I/W_ACK).
- Returns read data and a completion/error pulse to the CPU.
- Holds one outstanding transaction at a time; the CPU's LOAD_*, FETCH_*, STORE_* states wait on cpu_done.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 16, cycles in BUS without W_ACK before abort; only used with the timeout feature; must be >=2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- W_RST  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; sampled only when cpu_ready=1.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  byte address; must be word-aligned.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  unit idle, request accepted this cycle if cpu_req=1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_done; 1 = misaligned or timed out.
- cpu_rdata  out  DATA_W  read data, held until the next read completes.
- W_ADDR  out  ADDR_W  bus address.
- W_DAT_O  out  DATA_W  bus write data.
- W_DAT_I  in  DATA_W  bus read data.
- W_ACK  in  1  slave acknowledge.
- W_CYC  out  1  bus cycle active.
- W_STB  out  1  strobe; always equal to W_CYC.
- W_WE  out  1  write enable.

Behaviour:
- Reset (W_RST=0, asynchronous): state=IDLE; W_CYC=W_STB=W_WE=0; W_ADDR=W_DAT_O=0; cpu_done=cpu_err=0; cpu_rdata=0; timeout counter=0.
- Reset mid-transaction drops W_CYC immediately. No completion is reported.
- All outputs are registered. cpu_ready = (state==IDLE) is the only combinational output.
- States: IDLE, BUS.
- IDLE, cpu_req=1, cpu_addr[1:0]==0:
  - Latch addr, wdata and we into W_ADDR, W_DAT_O and W_WE.
  - Set W_CYC=W_STB=1 and go to BUS.
  - The bus cycle is visible one cycle after acceptance.
- IDLE, cpu_req=1, cpu_addr[1:0]!=0:
  - No bus cycle; stay IDLE.
  - Next cycle cpu_done=1, cpu_err=1; cpu_rdata unchanged.
- BUS with W_ACK=1:
  - Clear W_CYC/W_STB/W_WE and go to IDLE.
  - Next cycle cpu_done=1, cpu_err=0.
  - If it was a read, cpu_rdata <= W_DAT_I.
- BUS with W_ACK=0: hold all bus outputs stable.
- Minimum latency is 2 cycles, request edge to cpu_done (ack in first BUS cycle).
- cpu_done coincides with cpu_ready=1, so a new request may be accepted in the cycle cpu_done is high (back-to-back).
- W_ACK while in IDLE is ignored.
- cpu_done and cpu_err are single-cycle pulses; cpu_err=0 whenever cpu_done=0.
- W_DAT_O and W_ADDR keep their last values after a cycle ends; they are don't-care when W_CYC=0.

Optional Feature:
- Macro CPU_BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUS and increments on each BUS cycle without W_ACK.
  - When the count reaches TIMEOUT_CYCLES-1 with W_ACK=0: abort, clear W_CYC/W_STB, go to IDLE.
  - Next cycle cpu_done=1, cpu_err=1; cpu_rdata unchanged.
  - W_ACK in the terminal-count cycle wins: normal completion, err=0.
- Undefined: no counter; BUS waits indefinitely for W_ACK.

Decomposition:
- Package cpu_bus_pkg: state encoding (IDLE, BUS), default ADDR_W/DATA_W, alignment mask constant.
- Sub-module cpu_bus_timeout: counter with clear/enable/expire, instantiated only under CPU_BUS_TIMEOUT_EN.

Test Plan:
- Read at addr 0x0000_0010, slave acks 1 cycle after W_STB with W_DAT_I=0xDEADBEEF:
  - W_CYC high exactly 1 cycle, W_WE=0.
  - cpu_done at request+2, err=0, cpu_rdata=0xDEADBEEF.
- Write 0x1234_5678 to 0x0000_0100, ack delayed 3 cycles:
  - W_ADDR, W_DAT_O and W_WE=1 stable for all 3 wait cycles.
  - cpu_done once, err=0, cpu_rdata unchanged.
- Misaligned read at 0x0000_0013:
  - W_CYC never asserts.
  - cpu_done=1, cpu_err=1 next cycle.
- Back-to-back reads 0x0, 0x4, re-requested in the done cycle:
  - Second W_CYC rises the cycle after the first done; both complete with correct data.
- CPU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack:
  - W_CYC drops after 16 BUS cycles; done+err pulse.
  - A repeat run with ack on cycle 16 completes with err=0.
- W_RST asserted low during a BUS wait:
  - W_CYC=0 immediately, no cpu_done.
  - After release, a new read completes normally.
